// File: rtl/updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : updown_sweep_ctrl
// Description : Sequences an up/down counter through repeated sweeps between
//               a programmable lower and upper bound (lo -> hi -> lo is one
//               pass). It can hold the count for a programmable number of
//               extra cycles at each turning point. It provides a
//               start/busy/done handshake, a one-cycle error pulse when a
//               start is rejected, and an abort input.
//
// Ports       :
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active low
//   start     in   command strobe, only looked at while idle
//   abort     in   stops the sweep on the next edge (highest priority)
//   lo        in   [WIDTH]   lower bound, captured on an accepted start
//   hi        in   [WIDTH]   upper bound, captured on an accepted start
//   repeats   in   [RPT_W]   number of full passes, captured on start
//   dwell     in   [DWELL_W] extra hold cycles at turning points
//   cnt       out  [WIDTH]   counter value to the datapath
//   dir       out  1 = counting up, 0 = counting down
//   busy      out  sweep in progress
//   done      out  one-cycle pulse on normal completion
//   err       out  one-cycle pulse on a rejected start
//   pass_cnt  out  [RPT_W]   passes completed in the current/last sweep
//
// Revision    : 1.0  initial release
// ============================================================================
module updown_sweep_ctrl #(
  parameter int WIDTH   = 3,
  parameter int RPT_W   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [RPT_W-1:0]   repeats,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   cnt,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [RPT_W-1:0]   pass_cnt
);

  localparam logic [WIDTH-1:0]   c_cnt_one   = WIDTH'(1);
  localparam logic [RPT_W-1:0]   c_pass_one  = RPT_W'(1);
  localparam logic [DWELL_W-1:0] c_dwell_one = DWELL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UP     = 3'd1,
    S_PEAK   = 3'd2,
    S_DOWN   = 3'd3,
    S_TROUGH = 3'd4
  } state_t;

  state_t             r_state;

  // Configuration captured on an accepted start; the live inputs are
  // don't-care for the rest of the sweep.
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [RPT_W-1:0]   r_rpt;
  logic [DWELL_W-1:0] r_dwell;

  // Remaining extra hold cycles at the current turning point.
  logic [DWELL_W-1:0] r_dcnt;

  logic [WIDTH-1:0]   w_cnt_inc;
  logic [WIDTH-1:0]   w_cnt_dec;
  logic [RPT_W-1:0]   w_pass_next;
  logic               w_cfg_bad;
  logic               w_dwell_done;
  logic               w_last_pass;
  logic               w_step_up;
  logic               w_step_down;
  logic               w_finish;

  // A sweep is only meaningful with a non-empty range and at least one pass.
  assign w_cfg_bad    = (lo >= hi) || (repeats == '0);

  // The counter never steps past a bound, so these cannot wrap while the
  // step is actually applied.
  assign w_cnt_inc    = cnt + c_cnt_one;
  assign w_cnt_dec    = cnt - c_cnt_one;
  assign w_pass_next  = pass_cnt + c_pass_one;

  assign w_dwell_done = (r_dcnt == '0);
  assign w_last_pass  = (pass_cnt == r_rpt);

  // The turning-point states do double duty. When their hold time runs out,
  // they perform the first step of the next leg. The trough also hosts the
  // single-cycle final lo before done, because r_dcnt is loaded with zero
  // on the last pass.
  assign w_step_up    = (r_state == S_UP) ||
                        ((r_state == S_TROUGH) && w_dwell_done && !w_last_pass);
  assign w_step_down  = (r_state == S_DOWN) ||
                        ((r_state == S_PEAK) && w_dwell_done);
  assign w_finish     = (r_state == S_TROUGH) && w_dwell_done && w_last_pass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_rpt    <= '0;
      r_dwell  <= '0;
      r_dcnt   <= '0;
      cnt      <= '0;
      dir      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (r_state == S_IDLE) begin
        // Abort in the same cycle suppresses the start, including its error.
        if (start && !abort) begin
          if (w_cfg_bad) begin
            err <= 1'b1;
          end else begin
            r_lo     <= lo;
            r_hi     <= hi;
            r_rpt    <= repeats;
            r_dwell  <= dwell;
            r_dcnt   <= '0;
            cnt      <= lo;
            dir      <= 1'b1;
            busy     <= 1'b1;
            pass_cnt <= '0;
            r_state  <= S_UP;
          end
        end
      end else if (abort) begin
        // cnt, dir and pass_cnt keep their last values for inspection.
        r_state <= S_IDLE;
        r_dcnt  <= '0;
        busy    <= 1'b0;
      end else if (w_step_up) begin
        cnt <= w_cnt_inc;
        dir <= 1'b1;
        // When lo+1 == hi, the first step out of the trough already lands
        // on the peak. The check therefore sits on every upward step.
        if (w_cnt_inc == r_hi) begin
          if (r_dwell == '0) begin
            r_state <= S_DOWN;
          end else begin
            r_state <= S_PEAK;
            r_dcnt  <= r_dwell;
          end
        end else begin
          r_state <= S_UP;
        end
      end else if (w_step_down) begin
        cnt <= w_cnt_dec;
        dir <= 1'b0;
        if (w_cnt_dec == r_lo) begin
          pass_cnt <= w_pass_next;
          r_state  <= S_TROUGH;
          // The final trough is shown for one cycle only, with no dwell.
          r_dcnt   <= (w_pass_next == r_rpt) ? '0 : r_dwell;
        end else begin
          r_state <= S_DOWN;
        end
      end else if (w_finish) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else if (!w_dwell_done) begin
        r_dcnt <= r_dcnt - c_dwell_one;
      end else begin
        // Only unused state encodings reach this branch; drop back to idle.
        r_state <= S_IDLE;
        r_dcnt  <= '0;
        busy    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_sweep_ctrl
// Description : Directed self-checking bench for updown_sweep_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] lo = '0;
  logic [2:0] hi = '0;
  logic [3:0] repeats = '0;
  logic [3:0] dwell = '0;
  logic [2:0] cnt;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] pass_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  updown_sweep_ctrl #(
    .WIDTH   (3),
    .RPT_W   (4),
    .DWELL_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .lo       (lo),
    .hi       (hi),
    .repeats  (repeats),
    .dwell    (dwell),
    .cnt      (cnt),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .pass_cnt (pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_tests++;
    if (cnt !== 3'd0 || dir !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || pass_cnt !== 4'd0)
      begin n_fail++; $display("FAIL reset_state: cnt=%0d dir=%b busy=%b done=%b err=%b pass=%0d, expected all zero", cnt, dir, busy, done, err, pass_cnt); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if (cnt !== 3'd0 || busy !== 1'b0 || pass_cnt !== 4'd0)
      begin n_fail++; $display("FAIL reset_release: cnt=%0d busy=%b pass=%0d, expected 0/0/0", cnt, busy, pass_cnt); end
  endtask

  task automatic test_basic();
    logic [2:0] exp_c [9];
    logic       exp_d [9];
    exp_c = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1};
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    lo = 3'd1; hi = 3'd3; repeats = 4'd2; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (cnt !== exp_c[i] || dir !== exp_d[i] || busy !== 1'b1 || done !== 1'b0)
        begin n_fail++; $display("FAIL basic_step[%0d]: cnt=%0d dir=%b busy=%b done=%b, expected cnt=%0d dir=%b busy=1 done=0", i, cnt, dir, busy, done, exp_c[i], exp_d[i]); end
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 4'd2 || cnt !== 3'd1 || dir !== 1'b0)
      begin n_fail++; $display("FAIL basic_done: done=%b busy=%b pass=%0d cnt=%0d dir=%b, expected 1/0/2/1/0", done, busy, pass_cnt, cnt, dir); end
    tick();
    n_tests++;
    if (done !== 1'b0 || cnt !== 3'd1 || pass_cnt !== 4'd2)
      begin n_fail++; $display("FAIL basic_after: done=%b cnt=%0d pass=%0d, expected 0/1/2", done, cnt, pass_cnt); end
  endtask

  task automatic test_dwell();
    logic [2:0] q [$];
    logic [2:0] exp_c [8];
    logic       exp_d [8];
    // Full range 0..7, one pass, two extra cycles at the peak only.
    for (int v = 0; v < 8; v++) q.push_back(3'(v));
    q.push_back(3'd7);
    q.push_back(3'd7);
    for (int v = 6; v >= 0; v--) q.push_back(3'(v));
    lo = 3'd0; hi = 3'd7; repeats = 4'd1; dwell = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    dwell = 4'd0;
    for (int i = 0; i < 17; i++) begin
      n_tests++;
      if (cnt !== q[i] || busy !== 1'b1)
        begin n_fail++; $display("FAIL dwell_step[%0d]: cnt=%0d busy=%b, expected cnt=%0d busy=1", i, cnt, busy, q[i]); end
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 4'd1 || cnt !== 3'd0)
      begin n_fail++; $display("FAIL dwell_done: done=%b busy=%b pass=%0d cnt=%0d, expected 1/0/1/0", done, busy, pass_cnt, cnt); end
    tick();

    // Adjacent bounds with dwell=1: peak and middle trough each shown twice.
    exp_c = '{3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3};
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    lo = 3'd3; hi = 3'd4; repeats = 4'd2; dwell = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cnt !== exp_c[i] || dir !== exp_d[i] || busy !== 1'b1)
        begin n_fail++; $display("FAIL narrow_step[%0d]: cnt=%0d dir=%b busy=%b, expected cnt=%0d dir=%b busy=1", i, cnt, dir, busy, exp_c[i], exp_d[i]); end
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 4'd2 || cnt !== 3'd3)
      begin n_fail++; $display("FAIL narrow_done: done=%b busy=%b pass=%0d cnt=%0d, expected 1/0/2/3", done, busy, pass_cnt, cnt); end
    tick();
  endtask

  task automatic test_invalid();
    // Previous sweep left cnt=3, pass_cnt=2.
    lo = 3'd5; hi = 3'd5; repeats = 4'd1; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || cnt !== 3'd3 || pass_cnt !== 4'd2)
      begin n_fail++; $display("FAIL invalid_eq: err=%b busy=%b cnt=%0d pass=%0d, expected 1/0/3/2", err, busy, cnt, pass_cnt); end
    tick();
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL invalid_pulse: err=%b busy=%b, expected 0/0", err, busy); end
    lo = 3'd1; hi = 3'd3; repeats = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || cnt !== 3'd3 || pass_cnt !== 4'd2)
      begin n_fail++; $display("FAIL invalid_rpt0: err=%b busy=%b cnt=%0d pass=%0d, expected 1/0/3/2", err, busy, cnt, pass_cnt); end
    lo = 3'd6; hi = 3'd2; repeats = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || cnt !== 3'd3)
      begin n_fail++; $display("FAIL invalid_lo_gt_hi: err=%b busy=%b cnt=%0d, expected 1/0/3", err, busy, cnt); end
    tick();
  endtask

  task automatic test_abort();
    lo = 3'd0; hi = 3'd7; repeats = 4'd3; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && cnt !== 3'd4; k++) tick();
    n_tests++;
    if (cnt !== 3'd4 || busy !== 1'b1)
      begin n_fail++; $display("FAIL abort_reach: cnt=%0d busy=%b, expected 4/1 within budget", cnt, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cnt !== 3'd4 ||
        pass_cnt !== 4'd0 || dir !== 1'b1)
      begin n_fail++; $display("FAIL abort_stop: busy=%b done=%b err=%b cnt=%0d pass=%0d dir=%b, expected 0/0/0/4/0/1", busy, done, err, cnt, pass_cnt, dir); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || cnt !== 3'd4)
        begin n_fail++; $display("FAIL abort_hold[%0d]: done=%b busy=%b cnt=%0d, expected 0/0/4", k, done, busy, cnt); end
    end
    // Abort and start together while idle: start is dropped, no error.
    lo = 3'd1; hi = 3'd3; repeats = 4'd1; start = 1'b1; abort = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || err !== 1'b0 || cnt !== 3'd4)
      begin n_fail++; $display("FAIL abort_start_valid: busy=%b err=%b cnt=%0d, expected 0/0/4", busy, err, cnt); end
    lo = 3'd5; hi = 3'd5;
    tick();
    n_tests++;
    if (busy !== 1'b0 || err !== 1'b0)
      begin n_fail++; $display("FAIL abort_start_invalid: busy=%b err=%b, expected 0/0", busy, err); end
    start = 1'b0; abort = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_a [5];
    logic [2:0] exp_b [5];
    exp_a = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1};
    exp_b = '{3'd2, 3'd3, 3'd4, 3'd3, 3'd2};
    lo = 3'd1; hi = 3'd3; repeats = 4'd1; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (cnt !== exp_a[i] || busy !== 1'b1)
        begin n_fail++; $display("FAIL ignore_step[%0d]: cnt=%0d busy=%b, expected cnt=%0d busy=1", i, cnt, busy, exp_a[i]); end
      // Starts with a different config while busy must have no effect.
      if (i == 1 || i == 2) begin
        lo = 3'd2; hi = 3'd4; repeats = 4'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt !== 3'd1 || pass_cnt !== 4'd1)
      begin n_fail++; $display("FAIL ignore_done: done=%b busy=%b cnt=%0d pass=%0d, expected 1/0/1/1", done, busy, cnt, pass_cnt); end
    lo = 3'd2; hi = 3'd4; repeats = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (cnt !== exp_b[i] || busy !== 1'b1 || done !== 1'b0 || (i == 0 && pass_cnt !== 4'd0))
        begin n_fail++; $display("FAIL b2b_step[%0d]: cnt=%0d busy=%b done=%b pass=%0d, expected cnt=%0d busy=1 done=0", i, cnt, busy, done, pass_cnt, exp_b[i]); end
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt !== 3'd2 || pass_cnt !== 4'd1)
      begin n_fail++; $display("FAIL b2b_done: done=%b busy=%b cnt=%0d pass=%0d, expected 1/0/2/1", done, busy, cnt, pass_cnt); end
    tick();
  endtask

  task automatic test_async_reset();
    lo = 3'd0; hi = 3'd7; repeats = 4'd2; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 60 && !(pass_cnt === 4'd1 && dir === 1'b0 && cnt === 3'd5); k++) tick();
    n_tests++;
    if (pass_cnt !== 4'd1 || dir !== 1'b0 || cnt !== 3'd5 || busy !== 1'b1)
      begin n_fail++; $display("FAIL areset_reach: pass=%0d dir=%b cnt=%0d busy=%b, expected 1/0/5/1 within budget", pass_cnt, dir, cnt, busy); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (cnt !== 3'd0 || busy !== 1'b0 || dir !== 1'b0 || pass_cnt !== 4'd0 || done !== 1'b0)
      begin n_fail++; $display("FAIL areset_immediate: cnt=%0d busy=%b dir=%b pass=%0d done=%b, expected all zero", cnt, busy, dir, pass_cnt, done); end
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if (cnt !== 3'd0 || busy !== 1'b0 || done !== 1'b0)
      begin n_fail++; $display("FAIL areset_after: cnt=%0d busy=%b done=%b, expected 0/0/0", cnt, busy, done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dwell();
    test_invalid();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
